// File: rtl/fp_mat_mem_slave.sv
// fp_mat_mem_slave: Avalon-MM pipelined-read slave holding a 32x32 fp32 matrix.
// Reads return after READ_LATENCY cycles. Outstanding reads are capped at
// MAX_PENDING, and optional periodic waitrequest stalls can be injected.
// Nios-side writes preload the RAM.
module fp_mat_mem_slave #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_PENDING  = 4,
    parameter int unsigned STALL_PERIOD = 0,
    parameter logic [31:0] NaN          = 32'h7FC0_0000
) (
    input  logic        avalon_clk,
    input  logic        avalon_reset,
    input  logic [23:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        protocol_error
);

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned PEND_W  = 4;
    localparam int unsigned STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    // Word storage; deliberately not reset so contents survive avalon_reset
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Read token pipeline: stage 0 captures RAM data at acceptance, last stage drives the bus
    logic [READ_LATENCY-1:0] vld_q,  vld_d;
    logic [DATA_W-1:0]       data_q [READ_LATENCY];
    logic [DATA_W-1:0]       data_d [READ_LATENCY];

    logic [PEND_W-1:0]  pending_q,   pending_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               perr_q,      perr_d;

    logic [IDX_W-1:0] idx_c;
    logic             in_range_c;
    logic             rw_clash_c;
    logic             stall_tick_c;
    logic             full_c;
    logic             rd_acc_c;
    logic             wr_acc_c;
    logic             ret_c;
    logic             addr_unused_c;

    // Address decode: word index plus upper-bit range check
    assign idx_c         = address[IDX_W+1:2];
    assign in_range_c    = (address[ADDR_W-1:IDX_W+2] == '0);
    assign addr_unused_c = ^address[1:0];

    // Request qualification
    assign rw_clash_c   = read & write;
    assign stall_tick_c = (STALL_PERIOD != 0) &&
                          (stall_cnt_q == STALL_W'(STALL_PERIOD - 1));
    assign full_c       = (pending_q == PEND_W'(MAX_PENDING));
    assign waitrequest  = avalon_reset | full_c | stall_tick_c | rw_clash_c;

    assign rd_acc_c = read  & ~waitrequest;
    assign wr_acc_c = write & ~waitrequest & in_range_c;
    assign ret_c    = vld_q[READ_LATENCY-1];

    // Registered response outputs come straight off the last pipeline stage
    assign readdata       = data_q[READ_LATENCY-1];
    assign readdatavalid  = vld_q[READ_LATENCY-1];
    assign protocol_error = perr_q;

    // Next-state: pending count, token shift, stall counter, sticky error
    always_comb begin
        pending_d   = pending_q;
        vld_d       = vld_q;
        data_d      = data_q;
        stall_cnt_d = stall_cnt_q;
        perr_d      = perr_q;

        // acceptance and return in the same cycle cancel out
        pending_d = pending_q + PEND_W'(rd_acc_c) - PEND_W'(ret_c);

        // stage 0 samples the RAM in the acceptance cycle, so later writes cannot leak in
        vld_d[0] = rd_acc_c;
        if (rd_acc_c) begin
            data_d[0] = in_range_c ? mem_q[idx_c] : NaN;
        end

        // data only moves with a valid token, so the output holds its last value
        for (int unsigned k = 1; k < READ_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
                data_d[k] = data_q[k-1];
            end
        end

        if (STALL_PERIOD != 0) begin
            stall_cnt_d = stall_tick_c ? '0 : stall_cnt_q + STALL_W'(1);
        end else begin
            stall_cnt_d = '0;
        end

        if (rw_clash_c) begin
            perr_d = 1'b1;
        end
    end

    // Control and pipeline registers; reset drops every in-flight read
    always_ff @(posedge avalon_clk or posedge avalon_reset) begin
        if (avalon_reset) begin
            pending_q   <= '0;
            vld_q       <= '0;
            data_q      <= '{default: '0};
            stall_cnt_q <= '0;
            perr_q      <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
            stall_cnt_q <= stall_cnt_d;
            perr_q      <= perr_d;
        end
    end

    // RAM write port; lands at the end of the acceptance cycle
    always_ff @(posedge avalon_clk) begin
        if (wr_acc_c) begin
            mem_q[idx_c] <= writedata;
        end
    end

endmodule

// File: tb/tb_fp_mat_mem_slave.sv
// Directed bench for fp_mat_mem_slave. Four instances cover the default
// configuration, MAX_PENDING=1, STALL_PERIOD=4, and READ_LATENCY=4 (reset drop).
`timescale 1ns/1ps
module tb_fp_mat_mem_slave;

    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] addr    [NDUT];
    logic        rd      [NDUT];
    logic        wr      [NDUT];
    logic [31:0] wdata   [NDUT];
    logic        waitreq [NDUT];
    logic [31:0] rdata   [NDUT];
    logic        rdv     [NDUT];
    logic        perr    [NDUT];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] resp_b[$];
    logic [31:0] resp_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fp_mat_mem_slave #(
            .READ_LATENCY ((g == 3) ? 4 : 2),
            .MAX_PENDING  ((g == 1) ? 1 : 4),
            .STALL_PERIOD ((g == 2) ? 4 : 0)
        ) u_dut (
            .avalon_clk     (clk),
            .avalon_reset   (rst),
            .address        (addr[g]),
            .read           (rd[g]),
            .write          (wr[g]),
            .writedata      (wdata[g]),
            .waitrequest    (waitreq[g]),
            .readdata       (rdata[g]),
            .readdatavalid  (rdv[g]),
            .protocol_error (perr[g])
        );
    end

    // response collectors for the pending-limit and stall instances
    always @(negedge clk) begin
        if (rdv[1]) resp_b.push_back(rdata[1]);
        if (rdv[2]) resp_c.push_back(rdata[2]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // waits (bounded) for the current request on instance k to be accepted; ends at that negedge
    task automatic wait_accept(input int k, input string tag);
        int n = 0;
        @(negedge clk);
        while (waitreq[k] && n < 32) begin
            @(negedge clk);
            n++;
        end
        if (waitreq[k]) check(tag, 32'(waitreq[k]), 32'd0);
    endtask

    task automatic do_write(input int k, input logic [23:0] a, input logic [31:0] d);
        addr[k] = a; wdata[k] = d; wr[k] = 1'b1;
        wait_accept(k, "write_accept_timeout");
        @(posedge clk); #1;
        wr[k] = 1'b0;
    endtask

    task automatic do_read(input int k, input logic [23:0] a, output logic [31:0] d);
        int n = 0;
        addr[k] = a; rd[k] = 1'b1;
        wait_accept(k, "read_accept_timeout");
        @(posedge clk); #1;
        rd[k] = 1'b0;
        @(negedge clk);
        while (!rdv[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdv[k]) check("read_resp_timeout", 32'(rdv[k]), 32'd1);
        d = rdata[k];
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int errs, stalls, i, n, nstall, last_stall, spacing_err, rdv_cnt;
        int acc[6];

        for (int k = 0; k < NDUT; k++) begin
            addr[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0; wdata[k] = '0;
        end

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_waitreq", 32'(waitreq[0]), 32'd1);
        check("rst_readdata", rdata[0], 32'd0);
        check("rst_rdv", 32'(rdv[0]), 32'd0);
        check("rst_perr", 32'(perr[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_waitreq", 32'(waitreq[0]), 32'd0);
        @(posedge clk); #1;

        // ---- single write then read, latency 2 ----
        do_write(0, 24'h000010, 32'h3F80_0000);
        addr[0] = 24'h000010; rd[0] = 1'b1;
        @(negedge clk);
        check("t1_accept", 32'(waitreq[0]), 32'd0);
        @(posedge clk); #1;
        rd[0] = 1'b0;
        @(negedge clk);
        check("t1_rdv_t1", 32'(rdv[0]), 32'd0);
        @(negedge clk);
        check("t1_rdv_t2", 32'(rdv[0]), 32'd1);
        check("t1_data_t2", rdata[0], 32'h3F80_0000);
        @(negedge clk);
        check("t1_rdv_t3", 32'(rdv[0]), 32'd0);
        check("t1_hold_t3", rdata[0], 32'h3F80_0000);
        @(posedge clk); #1;

        // ---- 256 back-to-back reads ----
        for (int w = 0; w < 256; w++) do_write(0, 24'(w * 4), 32'(w));
        errs = 0; stalls = 0;
        for (int c = 0; c < 259; c++) begin
            rd[0] = (c < 256); addr[0] = 24'(c * 4);
            @(negedge clk);
            if (rd[0] && waitreq[0]) stalls++;
            if (c >= 2 && c < 258) begin
                if (!rdv[0] || rdata[0] !== 32'(c - 2)) errs++;
            end else if (rdv[0]) errs++;
            @(posedge clk); #1;
        end
        rd[0] = 1'b0;
        check("b2b_stalls", 32'(stalls), 32'd0);
        check("b2b_data_errs", 32'(errs), 32'd0);

        // ---- out-of-range read and write ----
        do_read(0, 24'h001000, d);
        check("oor_read_nan", d, 32'h7FC0_0000);
        do_write(0, 24'h001000, 32'h1234_5678);
        do_read(0, 24'h000000, d);
        check("oor_word0_kept", d, 32'd0);

        // ---- MAX_PENDING=1: one acceptance per 3 cycles ----
        for (int w = 0; w < 6; w++) do_write(1, 24'(w * 4), 32'hB000_0000 + 32'(w));
        resp_b.delete();
        rd[1] = 1'b1; i = 0; n = 0;
        while (i < 6 && n < 60) begin
            addr[1] = 24'(i * 4);
            @(negedge clk);
            n++;
            if (!waitreq[1]) begin
                acc[i] = cyc;
                i++;
            end
            @(posedge clk); #1;
        end
        rd[1] = 1'b0;
        check("mp1_accepts", 32'(i), 32'd6);
        for (int j = 1; j < 6; j++) check("mp1_interval", 32'(acc[j] - acc[j-1]), 32'd3);
        n = 0;
        while (resp_b.size() < 6 && n < 30) begin
            @(posedge clk); n++;
        end
        #1;
        check("mp1_resp_count", 32'(resp_b.size()), 32'd6);
        for (int j = 0; j < 6; j++) check("mp1_resp_data", resp_b[j], 32'hB000_0000 + 32'(j));

        // ---- STALL_PERIOD=4: 12 reads in 16 cycles ----
        for (int w = 0; w < 12; w++) do_write(2, 24'(w * 4), 32'hC000_0000 + 32'(w));
        resp_c.delete();
        n = 0;
        @(negedge clk);
        while (!waitreq[2] && n < 10) begin
            @(negedge clk); n++;
        end
        if (!waitreq[2]) check("stall_phase", 32'(waitreq[2]), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd[2] = 1'b1; i = 0; n = 0; nstall = 0; last_stall = -1; spacing_err = 0;
        while (i < 12 && n < 40) begin
            addr[2] = 24'(i * 4);
            @(negedge clk);
            n++;
            if (waitreq[2]) begin
                nstall++;
                if (last_stall >= 0 && cyc - last_stall != 4) spacing_err++;
                last_stall = cyc;
            end else i++;
            @(posedge clk); #1;
        end
        rd[2] = 1'b0;
        check("stall_cycles", 32'(n), 32'd16);
        check("stall_count", 32'(nstall), 32'd4);
        check("stall_spacing", 32'(spacing_err), 32'd0);
        n = 0;
        while (resp_c.size() < 12 && n < 30) begin
            @(posedge clk); n++;
        end
        #1;
        check("stall_resp_count", 32'(resp_c.size()), 32'd12);
        errs = 0;
        for (int j = 0; j < 12; j++) if (resp_c[j] !== 32'hC000_0000 + 32'(j)) errs++;
        check("stall_resp_order", 32'(errs), 32'd0);

        // ---- read&write clash, then reset with reads in flight (latency 4) ----
        do_write(3, 24'h000014, 32'h4000_0000);
        addr[3] = 24'h000014; wdata[3] = 32'd0; rd[3] = 1'b1; wr[3] = 1'b1;
        @(negedge clk);
        check("clash_waitreq", 32'(waitreq[3]), 32'd1);
        check("clash_perr_same_cycle", 32'(perr[3]), 32'd0);
        @(posedge clk); #1;
        rd[3] = 1'b0; wr[3] = 1'b0;
        @(negedge clk);
        check("clash_perr_set", 32'(perr[3]), 32'd1);
        @(posedge clk); #1;
        do_read(3, 24'h000014, d);
        check("clash_word5_kept", d, 32'h4000_0000);

        addr[3] = 24'h000014; rd[3] = 1'b1;
        @(negedge clk);
        check("rst_rd1_accept", 32'(waitreq[3]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_rd2_accept", 32'(waitreq[3]), 32'd0);
        @(posedge clk); #1;
        rd[3] = 1'b0; rst = 1'b1;
        rdv_cnt = 0;
        @(negedge clk);
        if (rdv[3]) rdv_cnt++;
        check("rst_perr_cleared", 32'(perr[3]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        if (rdv[3]) rdv_cnt++;
        check("rst_release_waitreq", 32'(waitreq[3]), 32'd0);
        repeat (6) begin
            @(negedge clk);
            if (rdv[3]) rdv_cnt++;
        end
        check("rst_dropped_reads", 32'(rdv_cnt), 32'd0);
        check("rst_perr_after", 32'(perr[3]), 32'd0);
        @(posedge clk); #1;
        do_read(3, 24'h000014, d);
        check("rst_ram_kept_d", d, 32'h4000_0000);
        do_read(0, 24'h000020, d);
        check("rst_ram_kept_a", d, 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
